z80_bus_target: RTL and testbench
=================================

Z80_BUS_TARGET -- requirements
Module: z80_bus_target

Interface
REQ-001 The block SHALL have parameter MEM_BASE, default 16'h8000, window base compared against masked A.
REQ-002 The block SHALL have parameter MEM_MASK, default 16'hC000, address bits used for window decode.
REQ-003 The block SHALL have parameter IO_PORT, default 8'h40, I/O port number (A[7:0]) of the control register.
REQ-004 The block SHALL have the following ports:
- CLK  in  1  Z80 system clock; every flop is rising-edge on it.
- RESET  in  1  asynchronous, active-high reset.
- nM1, nMREQ, nIORQ, nRD, nWR, nRFSH  in  1 each  Z80 bus strobes, active-low.
- A  in  16  Z80 address.
- D_in  in  8  Z80 data bus as driven by the CPU.
- D_out  out  8  data presented to the CPU.
- D_out_en  out  1  high while D_out drives the bus.
- nWAIT  out  1  wait request to the CPU, active-low.
- nINT  out  1  interrupt request to the CPU, active-low.
- irq  in  1  peripheral interrupt source, rising-edge sensitive.
- mem_req  out  1  back-end request, held until mem_ack.
- mem_we  out  1  back-end write (1) or read (0), valid with mem_req.
- mem_addr  out  16  back-end address, valid with mem_req.
- mem_wdata  out  8  back-end write data, valid with mem_req.
- mem_rdata  in  8  back-end read data, valid with mem_ack.
- mem_ack  in  1  single-cycle back-end completion pulse.

Function
REQ-005 mem_sel SHALL be true when nMREQ=0, nRFSH=1, nM1 or nRD low or high as below, and (A & MEM_MASK)==(MEM_BASE & MEM_MASK).
REQ-006 FSM states SHALL be IDLE, RD_REQ, RD_DRIVE, WR_WAIT, WR_REQ, DONE.
REQ-007 IDLE: mem_sel and nRD=0 SHALL go to RD_REQ. Mem_sel and nRD=1 and nWR=1 SHALL go to WR_WAIT. In both cases nWAIT SHALL be registered low on that same edge.
REQ-008 RD_REQ SHALL assert mem_req=1, mem_we=0, mem_addr=A latched at IDLE exit. On mem_ack it SHALL latch mem_rdata into D_out, drop mem_req, release nWAIT=1, and go to RD_DRIVE.
REQ-009 RD_DRIVE SHALL hold D_out_en=1 while nRD=0. When nRD=1 or nMREQ=1 it SHALL clear D_out_en and go to IDLE.
REQ-010 WR_WAIT SHALL keep nWAIT=0. When nWR=0 it SHALL latch D_in into mem_wdata and go to WR_REQ.
REQ-011 WR_REQ SHALL assert mem_req=1, mem_we=1. On mem_ack it SHALL release nWAIT=1 and go to DONE.
REQ-012 DONE SHALL return to IDLE when nMREQ=1. A new cycle SHALL NOT start until nMREQ has been seen high.
REQ-013 Refresh cycles (nRFSH=0) and accesses outside the window SHALL leave every output unchanged.
REQ-014 mem_ack received while mem_req=0 SHALL be ignored.
REQ-015 mem_req SHALL never deassert before mem_ack; a strobe deasserting mid-request SHALL NOT abort the back-end transaction.
REQ-016 An I/O write (nIORQ=0, nM1=1, nWR=0, A[7:0]=IO_PORT) SHALL load ctrl[7:0]:
- ctrl[7:1] = interrupt vector bits 7:1 (bit 0 of the vector is always 0).
- ctrl[0] = interrupt enable.
REQ-017 An I/O read of IO_PORT SHALL drive D_out={6'b0, pending, ctrl[0]} with D_out_en=1 while nRD=0 and nIORQ=0, with no wait states.
REQ-018 A rising edge of irq (registered compare against the previous sample) SHALL set pending. nINT SHALL be ~(pending & ctrl[0]).
REQ-019 Interrupt acknowledge (nM1=0, nIORQ=0) while nINT=0 SHALL drive D_out={ctrl[7:1],1'b0}, D_out_en=1 until nIORQ=1, and clear pending.
REQ-020 An irq edge coinciding with the acknowledge clear SHALL leave pending set, so set wins over clear.
REQ-021 D_out_en SHALL be high only in RD_DRIVE, an I/O read, or an acknowledge. These are mutually exclusive by strobe decode.

Reset
REQ-022 While RESET=1 the block SHALL force:
- FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- D_out=0, D_out_en=0, nWAIT=1;
- ctrl=0, pending=0, so nINT=1;
- irq history = 0.
REQ-023 RESET asserted mid-transaction SHALL abandon the transaction immediately, and a later mem_ack SHALL be ignored.

Verification
REQ-024 Read A=16'h8123, back-end acks after 3 cycles with mem_rdata=8'h5A -> nWAIT low 3 cycles, mem_addr=16'h8123, D_out=8'h5A with D_out_en=1 until nRD=1.
REQ-025 Write A=16'hBFFF, D_in=8'hC3, ack after 1 cycle -> mem_we=1, mem_wdata=8'hC3, nWAIT released on ack, return to IDLE after nMREQ=1.
REQ-026 Read A=16'h4000 and a refresh cycle with A=16'h8000 -> no mem_req, nWAIT=1, D_out_en=0.
REQ-027 OUT (8'h40),8'hA1, then irq rising edge, then acknowledge cycle -> nINT=0, D_out=8'hA0 during the acknowledge, nINT=1 afterwards; an irq edge on the clear cycle keeps nINT=0.
REQ-028 RESET pulse during RD_REQ, then a late mem_ack -> all outputs at reset values, no D_out_en, FSM=IDLE.

Source files
------------

// File: rtl/z80_bus_target.sv
// z80_bus_target: Z80 memory-window target with wait-stated back-end handshake and an I/O control/interrupt port.
module z80_bus_target #(
    parameter logic [15:0] MEM_BASE = 16'h8000,
    parameter logic [15:0] MEM_MASK = 16'hC000,
    parameter logic [7:0]  IO_PORT  = 8'h40
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_out_en,
    output logic        nWAIT,
    output logic        nINT,
    input  logic        irq,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_DRIVE, WR_WAIT, WR_REQ, DONE} state_t;
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, nwait_q, nwait_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d, d_out_q, d_out_d, ctrl_q, ctrl_d;
    logic        pending_q, pending_d, irq_prev_q, irq_prev_d, ack_q, ack_d;
    logic        mem_sel, io_hit, io_rd, io_wr, int_req, ack_clr;
    always_comb begin
        mem_sel    = !nMREQ && nRFSH && ((A & MEM_MASK) == (MEM_BASE & MEM_MASK));
        io_hit     = !nIORQ && nM1 && (A[7:0] == IO_PORT);
        io_rd      = io_hit && !nRD && !RESET;
        io_wr      = io_hit && !nWR;
        int_req    = pending_q && ctrl_q[0];
        // ack_q keeps the vector on the bus after pending (and hence nINT) has cleared
        ack_d      = !nIORQ && (ack_q || (!nM1 && int_req));
        ack_clr    = !nM1 && !nIORQ && int_req && !ack_q;
        irq_prev_d = irq;
        pending_d  = (irq && !irq_prev_q) || (pending_q && !ack_clr);
        ctrl_d     = io_wr ? D_in : ctrl_q;
    end
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_out_d     = d_out_q;
        nwait_d     = nwait_q;
        case (state_q)
            IDLE: if (mem_sel && (!nRD || nWR)) begin
                state_d    = nRD ? WR_WAIT : RD_REQ;
                mem_addr_d = A;
                mem_req_d  = !nRD;
                mem_we_d   = 1'b0;
                nwait_d    = 1'b0;
            end
            RD_REQ: if (mem_ack) begin
                d_out_d   = mem_rdata;
                mem_req_d = 1'b0;
                nwait_d   = 1'b1;
                state_d   = RD_DRIVE;
            end
            // nRD rising ahead of nMREQ parks in DONE so no cycle restarts before nMREQ is high
            RD_DRIVE: if (nRD || nMREQ) state_d = nMREQ ? IDLE : DONE;
            WR_WAIT: if (!nWR) begin
                mem_wdata_d = D_in;
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                state_d     = WR_REQ;
            end
            WR_REQ: if (mem_ack) begin
                mem_req_d = 1'b0;
                nwait_d   = 1'b1;
                state_d   = DONE;
            end
            DONE: if (nMREQ) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            d_out_q     <= '0;
            nwait_q     <= 1'b1;
            ctrl_q      <= '0;
            pending_q   <= 1'b0;
            irq_prev_q  <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_out_q     <= d_out_d;
            nwait_q     <= nwait_d;
            ctrl_q      <= ctrl_d;
            pending_q   <= pending_d;
            irq_prev_q  <= irq_prev_d;
            ack_q       <= ack_d;
        end
    end
    assign D_out_en  = (state_q == RD_DRIVE && !nRD && !nMREQ) || io_rd || ack_d;
    assign D_out     = io_rd ? {6'b0, pending_q, ctrl_q[0]} : ack_d ? {ctrl_q[7:1], 1'b0} : d_out_q;
    assign nWAIT     = nwait_q;
    assign nINT      = !int_req;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_z80_bus_target.sv
// tb_z80_bus_target: directed-vector bench for the Z80 bus target.
module tb_z80_bus_target;
    logic        CLK = 1'b0, RESET = 1'b1;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [15:0] A;
    logic [7:0]  D_in, D_out, mem_rdata, mem_wdata;
    logic        D_out_en, nWAIT, nINT, irq, mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    int          vecs = 0, errs = 0;

    z80_bus_target dut (
        .CLK(CLK), .RESET(RESET), .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD),
        .nWR(nWR), .nRFSH(nRFSH), .A(A), .D_in(D_in), .D_out(D_out), .D_out_en(D_out_en),
        .nWAIT(nWAIT), .nINT(nINT), .irq(irq), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    task tick;
        @(posedge CLK);
        #1;
    endtask

    task bus_idle;
        nM1 = 1; nMREQ = 1; nIORQ = 1; nRD = 1; nWR = 1; nRFSH = 1;
    endtask

    task test_reset;
        tick;
        vecs++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
        vecs++; if (mem_we !== 1'b0) begin errs++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
        vecs++; if (mem_addr !== 16'h0) begin errs++; $display("FAIL rst_mem_addr got=%h exp=0000", mem_addr); end
        vecs++; if (mem_wdata !== 8'h0) begin errs++; $display("FAIL rst_mem_wdata got=%h exp=00", mem_wdata); end
        vecs++; if (D_out !== 8'h0) begin errs++; $display("FAIL rst_d_out got=%h exp=00", D_out); end
        vecs++; if (D_out_en !== 1'b0) begin errs++; $display("FAIL rst_d_out_en got=%b exp=0", D_out_en); end
        vecs++; if (nWAIT !== 1'b1) begin errs++; $display("FAIL rst_nwait got=%b exp=1", nWAIT); end
        vecs++; if (nINT !== 1'b1) begin errs++; $display("FAIL rst_nint got=%b exp=1", nINT); end
        RESET = 0;
        tick;
        vecs++; if (nWAIT !== 1'b1 || mem_req !== 1'b0) begin errs++; $display("FAIL post_rst nwait=%b mem_req=%b exp=1/0", nWAIT, mem_req); end
    endtask

    task test_read;
        int low;
        low = 0;
        A = 16'h8123; nMREQ = 0; nRD = 0;
        tick;
        vecs++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errs++; $display("FAIL rd_req req=%b we=%b exp=1/0", mem_req, mem_we); end
        vecs++; if (mem_addr !== 16'h8123) begin errs++; $display("FAIL rd_addr got=%h exp=8123", mem_addr); end
        if (nWAIT === 1'b0) low++;
        for (int i = 0; i < 2; i++) begin
            tick;
            if (nWAIT === 1'b0) low++;
        end
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rd_req_held got=%b exp=1", mem_req); end
        mem_ack = 1; mem_rdata = 8'h5A;
        tick;
        mem_ack = 0; mem_rdata = 8'h00;
        vecs++; if (low !== 3) begin errs++; $display("FAIL rd_wait_cycles got=%0d exp=3", low); end
        vecs++; if (nWAIT !== 1'b1 || mem_req !== 1'b0) begin errs++; $display("FAIL rd_ack nwait=%b req=%b exp=1/0", nWAIT, mem_req); end
        vecs++; if (D_out !== 8'h5A || D_out_en !== 1'b1) begin errs++; $display("FAIL rd_drive d_out=%h en=%b exp=5a/1", D_out, D_out_en); end
        tick;
        vecs++; if (D_out !== 8'h5A || D_out_en !== 1'b1) begin errs++; $display("FAIL rd_hold d_out=%h en=%b exp=5a/1", D_out, D_out_en); end
        bus_idle;
        #1;
        vecs++; if (D_out_en !== 1'b0) begin errs++; $display("FAIL rd_release en=%b exp=0", D_out_en); end
        tick;
    endtask

    task test_write;
        A = 16'hBFFF; nMREQ = 0; D_in = 8'hC3;
        tick;
        vecs++; if (nWAIT !== 1'b0 || mem_req !== 1'b0) begin errs++; $display("FAIL wr_wait nwait=%b req=%b exp=0/0", nWAIT, mem_req); end
        nWR = 0;
        tick;
        vecs++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errs++; $display("FAIL wr_req req=%b we=%b exp=1/1", mem_req, mem_we); end
        vecs++; if (mem_wdata !== 8'hC3 || mem_addr !== 16'hBFFF) begin errs++; $display("FAIL wr_data wdata=%h addr=%h exp=c3/bfff", mem_wdata, mem_addr); end
        vecs++; if (nWAIT !== 1'b0) begin errs++; $display("FAIL wr_nwait got=%b exp=0", nWAIT); end
        mem_ack = 1;
        tick;
        mem_ack = 0;
        vecs++; if (nWAIT !== 1'b1 || mem_req !== 1'b0) begin errs++; $display("FAIL wr_ack nwait=%b req=%b exp=1/0", nWAIT, mem_req); end
        nWR = 1;
        tick;
        tick;
        vecs++; if (nWAIT !== 1'b1 || mem_req !== 1'b0) begin errs++; $display("FAIL wr_no_restart nwait=%b req=%b exp=1/0", nWAIT, mem_req); end
        nMREQ = 1;
        tick;
        A = 16'h8010; nMREQ = 0; nRD = 0;
        tick;
        vecs++; if (mem_req !== 1'b1 || mem_addr !== 16'h8010) begin errs++; $display("FAIL wr_then_rd req=%b addr=%h exp=1/8010", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 8'h11;
        tick;
        mem_ack = 0;
        bus_idle;
        tick;
    endtask

    task test_mid_strobe;
        A = 16'h8001; nMREQ = 0; nRD = 0;
        tick;
        bus_idle;
        tick;
        tick;
        vecs++; if (mem_req !== 1'b1 || mem_addr !== 16'h8001) begin errs++; $display("FAIL mid_held req=%b addr=%h exp=1/8001", mem_req, mem_addr); end
        vecs++; if (nWAIT !== 1'b0) begin errs++; $display("FAIL mid_nwait got=%b exp=0", nWAIT); end
        mem_ack = 1; mem_rdata = 8'h3C;
        tick;
        mem_ack = 0;
        vecs++; if (mem_req !== 1'b0 || nWAIT !== 1'b1 || D_out !== 8'h3C || D_out_en !== 1'b0) begin
            errs++; $display("FAIL mid_ack req=%b nwait=%b d_out=%h en=%b exp=0/1/3c/0", mem_req, nWAIT, D_out, D_out_en);
        end
        tick;
    endtask

    task test_ignored;
        A = 16'h4000; nMREQ = 0; nRD = 0;
        repeat (3) tick;
        vecs++; if (mem_req !== 1'b0 || nWAIT !== 1'b1 || D_out_en !== 1'b0) begin
            errs++; $display("FAIL out_window req=%b nwait=%b en=%b exp=0/1/0", mem_req, nWAIT, D_out_en);
        end
        bus_idle;
        tick;
        A = 16'h8000; nMREQ = 0; nRFSH = 0;
        repeat (3) tick;
        vecs++; if (mem_req !== 1'b0 || nWAIT !== 1'b1 || D_out_en !== 1'b0) begin
            errs++; $display("FAIL refresh req=%b nwait=%b en=%b exp=0/1/0", mem_req, nWAIT, D_out_en);
        end
        bus_idle;
        mem_ack = 1; mem_rdata = 8'hEE;
        tick;
        mem_ack = 0;
        tick;
        vecs++; if (mem_req !== 1'b0 || nWAIT !== 1'b1 || D_out !== 8'h3C) begin
            errs++; $display("FAIL stray_ack req=%b nwait=%b d_out=%h exp=0/1/3c", mem_req, nWAIT, D_out);
        end
    endtask

    task test_irq;
        A = 16'h0040; D_in = 8'hA1; nIORQ = 0; nWR = 0;
        tick;
        bus_idle;
        tick;
        vecs++; if (nINT !== 1'b1) begin errs++; $display("FAIL io_wr_nint got=%b exp=1", nINT); end
        nIORQ = 0; nRD = 0;
        #1;
        vecs++; if (D_out !== 8'h01 || D_out_en !== 1'b1 || nWAIT !== 1'b1) begin
            errs++; $display("FAIL io_rd d_out=%h en=%b nwait=%b exp=01/1/1", D_out, D_out_en, nWAIT);
        end
        bus_idle;
        #1;
        vecs++; if (D_out_en !== 1'b0) begin errs++; $display("FAIL io_rd_release en=%b exp=0", D_out_en); end
        irq = 1;
        tick;
        vecs++; if (nINT !== 1'b0) begin errs++; $display("FAIL irq_edge nint=%b exp=0", nINT); end
        nIORQ = 0; nRD = 0;
        #1;
        vecs++; if (D_out !== 8'h03) begin errs++; $display("FAIL io_rd_pend d_out=%h exp=03", D_out); end
        bus_idle;
        irq = 0;
        tick;
        nM1 = 0; nIORQ = 0;
        #1;
        vecs++; if (D_out !== 8'hA0 || D_out_en !== 1'b1) begin errs++; $display("FAIL iack d_out=%h en=%b exp=a0/1", D_out, D_out_en); end
        tick;
        vecs++; if (nINT !== 1'b1 || D_out !== 8'hA0 || D_out_en !== 1'b1) begin
            errs++; $display("FAIL iack_hold nint=%b d_out=%h en=%b exp=1/a0/1", nINT, D_out, D_out_en);
        end
        bus_idle;
        #1;
        vecs++; if (D_out_en !== 1'b0) begin errs++; $display("FAIL iack_release en=%b exp=0", D_out_en); end
        tick;
        nM1 = 0; nIORQ = 0;
        #1;
        vecs++; if (D_out_en !== 1'b0) begin errs++; $display("FAIL iack_no_int en=%b exp=0", D_out_en); end
        bus_idle;
        tick;
        irq = 1;
        tick;
        irq = 0;
        tick;
        vecs++; if (nINT !== 1'b0) begin errs++; $display("FAIL irq_edge2 nint=%b exp=0", nINT); end
        nM1 = 0; nIORQ = 0; irq = 1;
        tick;
        vecs++; if (nINT !== 1'b0 || D_out_en !== 1'b1) begin errs++; $display("FAIL set_wins nint=%b en=%b exp=0/1", nINT, D_out_en); end
        tick;
        bus_idle;
        irq = 0;
        tick;
        vecs++; if (nINT !== 1'b0) begin errs++; $display("FAIL set_wins_after nint=%b exp=0", nINT); end
    endtask

    task test_reset_mid;
        A = 16'h8000; nMREQ = 0; nRD = 0;
        tick;
        vecs++; if (mem_req !== 1'b1) begin errs++; $display("FAIL rm_req got=%b exp=1", mem_req); end
        RESET = 1;
        #1;
        vecs++; if (mem_req !== 1'b0 || nWAIT !== 1'b1 || nINT !== 1'b1 || mem_addr !== 16'h0) begin
            errs++; $display("FAIL rm_async req=%b nwait=%b nint=%b addr=%h exp=0/1/1/0000", mem_req, nWAIT, nINT, mem_addr);
        end
        vecs++; if (D_out !== 8'h0 || D_out_en !== 1'b0) begin errs++; $display("FAIL rm_dout d_out=%h en=%b exp=00/0", D_out, D_out_en); end
        bus_idle;
        tick;
        RESET = 0;
        tick;
        mem_ack = 1; mem_rdata = 8'hFF;
        tick;
        mem_ack = 0;
        vecs++; if (mem_req !== 1'b0 || nWAIT !== 1'b1 || D_out !== 8'h0 || D_out_en !== 1'b0) begin
            errs++; $display("FAIL rm_late_ack req=%b nwait=%b d_out=%h en=%b exp=0/1/00/0", mem_req, nWAIT, D_out, D_out_en);
        end
        A = 16'h8002; nMREQ = 0; nRD = 0;
        tick;
        vecs++; if (mem_req !== 1'b1 || mem_addr !== 16'h8002 || nWAIT !== 1'b0) begin
            errs++; $display("FAIL rm_idle req=%b addr=%h nwait=%b exp=1/8002/0", mem_req, mem_addr, nWAIT);
        end
        bus_idle;
    endtask

    initial begin
        bus_idle;
        A = 0; D_in = 0; irq = 0; mem_ack = 0; mem_rdata = 0;
        test_reset;
        test_read;
        test_write;
        test_mid_strobe;
        test_ignored;
        test_irq;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
